// File: rtl/bfly_addsub_mod.sv
`default_nettype none
// ============================================================================
// Module   : bfly_addsub_mod
// Brief    : NTT butterfly add/sub stage (Kyber 2x12b / Dilithium 1x23b) with
//            operand delay line and per-layer beat counter.
//            Optional macro INTT_HALF_EN adds half_en and 2^-1 mod q scaling.
// Revision : 1.0 - initial release
// ============================================================================
module bfly_addsub_mod #(
  parameter int MUL_LAT = 4,
  parameter int N_COEF  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic        mode,
`ifdef INTT_HALF_EN
  input  logic        half_en,
`endif
  input  logic [23:0] u_in,
  input  logic [23:0] prod_in,
  output logic [23:0] x_out,
  output logic [23:0] y_out,
  output logic        out_valid,
  output logic        stage_done
);

  localparam int               CNT_W     = $clog2(N_COEF / 2);
  localparam logic [CNT_W-1:0] C_LIM_KYB = CNT_W'(N_COEF / 4 - 1);
  localparam logic [CNT_W-1:0] C_LIM_DIL = CNT_W'(N_COEF / 2 - 1);
  localparam logic [23:0]      C_Q_KYB   = 24'd3329;
  localparam logic [23:0]      C_Q_DIL   = 24'd8380417;

  function automatic logic [23:0] f_add(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] q);
    logic [24:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[23:0];
  endfunction

  // a < q < 2^23, so a + q - b never overflows 24 bits
  function automatic logic [23:0] f_sub(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] q);
    if (a >= b) return a - b;
    return a + q - b;
  endfunction

`ifdef INTT_HALF_EN
  function automatic logic [23:0] f_half(input logic [23:0] r, input logic [23:0] q);
    logic [24:0] t;
    t = r[0] ? ({1'b0, r} + {1'b0, q}) : {1'b0, r};
    return t[24:1];
  endfunction
`endif

  logic              r_dl_valid [MUL_LAT];
  logic              r_dl_mode  [MUL_LAT];
  logic [23:0]       r_dl_u     [MUL_LAT];
`ifdef INTT_HALF_EN
  logic              r_dl_half  [MUL_LAT];
`endif
  logic [CNT_W-1:0]  r_cnt;
  logic [23:0]       r_x;
  logic [23:0]       r_y;
  logic              r_out_valid;
  logic              r_stage_done;

  logic              w_valid;
  logic              w_mode;
  logic              w_half;
  logic [23:0]       w_u;
  logic [23:0]       w_x;
  logic [23:0]       w_y;
  logic [CNT_W-1:0]  w_lim;

  assign w_valid = r_dl_valid[MUL_LAT-1];
  assign w_mode  = r_dl_mode[MUL_LAT-1];
  assign w_u     = r_dl_u[MUL_LAT-1];
`ifdef INTT_HALF_EN
  assign w_half  = r_dl_half[MUL_LAT-1];
`else
  assign w_half  = 1'b0;
`endif
  assign w_lim   = w_mode ? C_LIM_DIL : C_LIM_KYB;

  // Operand delay line: aligns u (and its per-beat controls) with prod_in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        r_dl_valid[k] <= 1'b0;
        r_dl_mode[k]  <= 1'b0;
        r_dl_u[k]     <= '0;
`ifdef INTT_HALF_EN
        r_dl_half[k]  <= 1'b0;
`endif
      end
    end else begin
      for (int k = MUL_LAT - 1; k > 0; k--) begin
        r_dl_valid[k] <= r_dl_valid[k-1] & ~clr;
        r_dl_mode[k]  <= r_dl_mode[k-1];
        r_dl_u[k]     <= r_dl_u[k-1];
`ifdef INTT_HALF_EN
        r_dl_half[k]  <= r_dl_half[k-1];
`endif
      end
      r_dl_valid[0] <= in_valid & ~clr;
      r_dl_mode[0]  <= mode;
      r_dl_u[0]     <= u_in;
`ifdef INTT_HALF_EN
      r_dl_half[0]  <= half_en;
`endif
    end
  end

  always_comb begin
    logic [23:0] a, b, s, d;
    w_x = '0;
    w_y = '0;
    a   = '0;
    b   = '0;
    s   = '0;
    d   = '0;
    if (w_mode) begin
      a = {1'b0, w_u[22:0]};
      b = {1'b0, prod_in[22:0]};
      s = f_add(a, b, C_Q_DIL);
      d = f_sub(a, b, C_Q_DIL);
`ifdef INTT_HALF_EN
      if (w_half) begin
        s = f_half(s, C_Q_DIL);
        d = f_half(d, C_Q_DIL);
      end
`endif
      w_x = {1'b0, s[22:0]};
      w_y = {1'b0, d[22:0]};
    end else begin
      for (int l = 0; l < 2; l++) begin
        a = {12'b0, w_u[12*l +: 12]};
        b = {12'b0, prod_in[12*l +: 12]};
        s = f_add(a, b, C_Q_KYB);
        d = f_sub(a, b, C_Q_KYB);
`ifdef INTT_HALF_EN
        if (w_half) begin
          s = f_half(s, C_Q_KYB);
          d = f_half(d, C_Q_KYB);
        end
`endif
        w_x[12*l +: 12] = s[11:0];
        w_y[12*l +: 12] = d[11:0];
      end
    end
  end

  // A clr also drops the beat that would have landed on this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_out_valid  <= 1'b0;
      r_stage_done <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_out_valid  <= w_valid & ~clr;
      r_stage_done <= 1'b0;
      if (clr) begin
        r_cnt <= '0;
      end else if (w_valid) begin
        r_x <= w_x;
        r_y <= w_y;
        if (r_cnt == w_lim) begin
          r_cnt        <= '0;
          r_stage_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign x_out      = r_x;
  assign y_out      = r_y;
  assign out_valid  = r_out_valid;
  assign stage_done = r_stage_done;

  logic w_unused;
  assign w_unused = w_half;

endmodule
`default_nettype wire

// File: tb/tb_bfly_addsub_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfly_addsub_mod
// Brief    : Self-checking bench for bfly_addsub_mod against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfly_addsub_mod;
  localparam int MUL_LAT = 4;
  localparam int N_COEF  = 256;
  localparam int QK      = 3329;
  localparam int QD      = 8380417;

  typedef struct {
    int          due;
    logic [23:0] x;
    logic [23:0] y;
    logic        md;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic [23:0] u_in = '0;
  logic [23:0] prod_in = '0;
  logic [23:0] x_out;
  logic [23:0] y_out;
  logic        out_valid;
  logic        stage_done;
`ifdef INTT_HALF_EN
  logic        half_en = 1'b0;
`endif

  int          ntests = 0;
  int          nfail  = 0;
  int          cyc    = 0;
  int          mcnt   = 0;
  int          ndone  = 0;
  logic [23:0] last_x = '0;
  logic [23:0] last_y = '0;
  rec_t        expq[$];
  logic [23:0] pq[$];

  always #5 clk = ~clk;

  bfly_addsub_mod #(.MUL_LAT(MUL_LAT), .N_COEF(N_COEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .mode       (mode),
`ifdef INTT_HALF_EN
    .half_en    (half_en),
`endif
    .u_in       (u_in),
    .prod_in    (prod_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .out_valid  (out_valid),
    .stage_done (stage_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int half_mod(input int r, input int q);
    return (r % 2 == 1) ? (r + q) / 2 : r / 2;
  endfunction

  // Reference: plain modular arithmetic on integers, lane by lane
  task automatic calc(input bit md, input logic [23:0] u, input logic [23:0] p, input bit he,
                      output logic [23:0] x, output logic [23:0] y);
    int a, b, xs, ys;
    x = '0;
    y = '0;
    if (md) begin
      a  = int'(u[22:0]);
      b  = int'(p[22:0]);
      xs = (a + b) % QD;
      ys = (a - b + QD) % QD;
      if (he) begin
        xs = half_mod(xs, QD);
        ys = half_mod(ys, QD);
      end
      x = 24'(xs);
      y = 24'(ys);
    end else begin
      for (int l = 0; l < 2; l++) begin
        a  = int'(u[12*l +: 12]);
        b  = int'(p[12*l +: 12]);
        xs = (a + b) % QK;
        ys = (a - b + QK) % QK;
        if (he) begin
          xs = half_mod(xs, QK);
          ys = half_mod(ys, QK);
        end
        x[12*l +: 12] = 12'(xs);
        y[12*l +: 12] = 12'(ys);
      end
    end
  endtask

  function automatic logic [23:0] rand_op(input bit md);
    if (md) return {1'b0, 23'($urandom_range(0, QD - 1))};
    return {12'($urandom_range(0, QK - 1)), 12'($urandom_range(0, QK - 1))};
  endfunction

  task automatic check_outputs();
    rec_t r;
    bit   d;
    if (stage_done === 1'b1) ndone++;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      r    = expq.pop_front();
      d    = (mcnt == (r.md ? N_COEF / 2 - 1 : N_COEF / 4 - 1));
      mcnt = d ? 0 : (mcnt + 1) % (N_COEF / 2);
      last_x = r.x;
      last_y = r.y;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("stage_done", 32'(stage_done), 32'(d));
    end else begin
      chk("out_valid_idle", 32'(out_valid), 32'd0);
      chk("stage_done_idle", 32'(stage_done), 32'd0);
    end
    chk("x_out", 32'(x_out), 32'(last_x));
    chk("y_out", 32'(y_out), 32'(last_y));
  endtask

  task automatic tick(input bit iv, input bit md, input logic [23:0] u, input logic [23:0] p,
                      input bit he, input bit c);
    rec_t r;
    in_valid = iv;
    mode     = md;
    u_in     = u;
    clr      = c;
`ifdef INTT_HALF_EN
    half_en  = he;
`endif
    pq.push_back(p);
    prod_in = pq.pop_front();
    if (c) begin
      expq.delete();
      mcnt = 0;
    end else if (iv) begin
      calc(md, u, p, he, r.x, r.y);
      r.md  = md;
      r.due = cyc + MUL_LAT + 1;
      expq.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rbeat(input bit md);
    tick(1'b1, md, rand_op(md), rand_op(md), 1'b0, 1'b0);
  endtask

  initial begin
    bit he;
    he = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) pq.push_back('0);

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(stage_done), 32'd0);
    rst = 1'b1;
    idle(2);

    // Directed: Kyber case, latency checked by the per-cycle model
    tick(1'b1, 1'b0, {12'd100, 12'd3000}, {12'd3300, 12'd500}, 1'b0, 1'b0);
    idle(MUL_LAT + 1);
    chk("k1_x", 32'(x_out), 32'({12'd71, 12'd171}));
    chk("k1_y", 32'(y_out), 32'({12'd129, 12'd2500}));

    tick(1'b1, 1'b1, 24'd8000000, 24'd500000, 1'b0, 1'b0);
    idle(MUL_LAT + 1);
    chk("d1_x", 32'(x_out), 32'd119583);
    chk("d1_y", 32'(y_out), 32'd7500000);
    chk("d1_x23", 32'(x_out[23]), 32'd0);

    tick(1'b1, 1'b0, {12'd3328, 12'd0}, {12'd1, 12'd0}, 1'b0, 1'b0);
    idle(MUL_LAT + 1);
    chk("kb_x", 32'(x_out), 32'({12'd0, 12'd0}));
    chk("kb_y", 32'(y_out), 32'({12'd3327, 12'd0}));

    tick(1'b1, 1'b1, 24'd0, 24'd8380416, 1'b0, 1'b0);
    idle(MUL_LAT + 1);
    chk("db_x", 32'(x_out), 32'd8380416);
    chk("db_y", 32'(y_out), 32'd1);

`ifdef INTT_HALF_EN
    tick(1'b1, 1'b0, {12'd100, 12'd3000}, {12'd3300, 12'd500}, 1'b1, 1'b0);
    idle(MUL_LAT + 1);
    chk("kh_x", 32'(x_out), 32'({12'd1700, 12'd1750}));
    chk("kh_y", 32'(y_out), 32'({12'd1729, 12'd1250}));
    he = 1'b1;
`endif

    // Layer counting from a cleared counter
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);
    ndone = 0;
    for (int i = 0; i < N_COEF / 4; i++) rbeat(1'b0);
    idle(MUL_LAT + 2);
    chk("kyber_layer_done", 32'(ndone), 32'd1);
    ndone = 0;
    for (int i = 0; i < N_COEF / 2; i++) rbeat(1'b1);
    idle(MUL_LAT + 2);
    chk("dil_layer_done", 32'(ndone), 32'd1);

    // Random mixed-mode traffic with gaps
    for (int i = 0; i < 60; i++) begin
      bit md;
      md = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)), md, rand_op(md), rand_op(md),
           he & 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(MUL_LAT + 2);

    // Asynchronous reset with beats in flight
    rbeat(1'b0);
    rbeat(1'b1);
    rbeat(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_x", 32'(x_out), 32'd0);
    chk("arst_y", 32'(y_out), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_done", 32'(stage_done), 32'd0);
    expq.delete();
    mcnt   = 0;
    last_x = '0;
    last_y = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    idle(MUL_LAT + 4);

    // clr mid-layer: the beat issued with clr is dropped, a full layer follows
    ndone = 0;
    for (int i = 0; i < 30; i++) rbeat(1'b0);
    tick(1'b1, 1'b0, rand_op(1'b0), rand_op(1'b0), 1'b0, 1'b1);
    for (int i = 0; i < N_COEF / 4 - 1; i++) rbeat(1'b0);
    idle(MUL_LAT + 2);
    chk("clr_no_early_done", 32'(ndone), 32'd0);
    rbeat(1'b0);
    idle(MUL_LAT + 2);
    chk("clr_full_layer_done", 32'(ndone), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
`default_nettype wire
